// File: rtl/isp_frame_src.sv
// isp_frame_src: raster Bayer-frame stream source fed from a frame buffer or a test pattern
// Ports: clk, rstn (async, active-low); start/abort frame control; src_sel/hblank/pat_val
// frame config latched at start; mem_rd_en/mem_addr/mem_rd_data fixed-latency frame-buffer
// read port; pixel_data_out/pixel_data_out_vld stream with sof/eol/frame_done flags; busy
// high while a frame is in flight.
module isp_frame_src #(
    parameter int DW = 16,
    parameter int H  = 1280,
    parameter int V  = 720,
    parameter int HW = 11,
    parameter int VW = 10,
    parameter int AW = 20
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          abort,
    input  logic [1:0]    src_sel,
    input  logic [7:0]    hblank,
    input  logic [DW-1:0] pat_val,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rd_data,
    output logic [DW-1:0] pixel_data_out,
    output logic          pixel_data_out_vld,
    output logic          sof,
    output logic          eol,
    output logic          frame_done,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK} state_t;
    typedef struct packed {
        logic          vld;
        logic          sof;
        logic          eol;
        logic          last;
        logic          mem;
        logic [DW-1:0] dat;
    } stg_t;

    state_t        state_q, state_d;
    logic [HW-1:0] h_q, h_d, ih;
    logic [VW-1:0] v_q, v_d, iv;
    logic [AW-1:0] a_q, a_d, ia, addr_q, addr_d;
    logic [7:0]    cnt_q, cnt_d, hb_q, hb_d, hb_c;
    logic [1:0]    sel_q, sel_d, sel_c;
    logic [DW-1:0] pat_q, pat_d, pat_c, dat_i, out_q, out_d;
    logic          go, iss, eol_i, last_i, rd_q, rd_d;
    logic          vld_q, vld_d, sof_q, sof_d, eol_q, eol_d, done_q, done_d;
    stg_t          p1_q, p1_d, p2_q, p2_d;

    // Busy covers the drain of the last pixels through the pipeline, so a new start
    // is only taken once frame_done has been presented.
    assign busy               = state_q != IDLE || p1_q.vld || p2_q.vld || vld_q;
    assign mem_rd_en          = rd_q;
    assign mem_addr           = addr_q;
    assign pixel_data_out     = out_q;
    assign pixel_data_out_vld = vld_q;
    assign sof                = sof_q;
    assign eol                = eol_q;
    assign frame_done         = done_q;

    always_comb begin
        // The start edge itself issues pixel (0,0) from the live config inputs, so the
        // first read is registered in the same edge that accepts start.
        go      = start && !abort && !busy;
        iss     = go || (state_q == ACTIVE && !abort);
        ih      = go ? '0 : h_q;
        iv      = go ? '0 : v_q;
        ia      = go ? '0 : a_q;
        hb_c    = go ? hblank : hb_q;
        sel_c   = go ? src_sel : sel_q;
        pat_c   = go ? pat_val : pat_q;
        eol_i   = ih == HW'(H - 1);
        last_i  = eol_i && iv == VW'(V - 1);
        dat_i   = sel_c == 2'd1 ? DW'(ih) + DW'(iv) :
                  sel_c == 2'd2 ? pat_c :
                  sel_c == 2'd3 ? {DW{ih[3] ^ iv[3]}} : '0;
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        a_d     = a_q;
        cnt_d   = cnt_q;
        hb_d    = hb_c;
        sel_d   = sel_c;
        pat_d   = pat_c;
        if (abort) begin
            state_d = IDLE;
        end else if (iss) begin
            state_d = ACTIVE;
            h_d     = ih + HW'(1);
            v_d     = iv;
            a_d     = ia + AW'(1);
            if (last_i) begin
                state_d = IDLE;
            end else if (eol_i) begin
                h_d     = '0;
                v_d     = iv + VW'(1);
                state_d = hb_c == 8'd0 ? ACTIVE : HBLANK;
                cnt_d   = hb_c - 8'd1;
            end
        end else if (state_q == HBLANK) begin
            cnt_d   = cnt_q - 8'd1;
            state_d = cnt_q == 8'd0 ? ACTIVE : HBLANK;
        end
        rd_d   = iss && sel_c == 2'd0;
        addr_d = iss ? ia : addr_q;
        // Pattern pixels ride two stages so they leave in the same cycle a memory read would.
        p1_d   = '{vld: iss, sof: go, eol: iss && eol_i, last: iss && last_i,
                   mem: sel_c == 2'd0, dat: dat_i};
        p2_d   = p1_q;
        if (abort) {p2_d.vld, p2_d.sof, p2_d.eol, p2_d.last} = 4'b0;
        vld_d  = p2_q.vld && !abort;
        sof_d  = p2_q.sof && !abort;
        eol_d  = p2_q.eol && !abort;
        done_d = p2_q.last && !abort;
        out_d  = p2_q.mem ? mem_rd_data : p2_q.dat;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            h_q     <= '0;
            v_q     <= '0;
            a_q     <= '0;
            cnt_q   <= '0;
            hb_q    <= '0;
            sel_q   <= '0;
            pat_q   <= '0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            vld_q   <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            a_q     <= a_d;
            cnt_q   <= cnt_d;
            hb_q    <= hb_d;
            sel_q   <= sel_d;
            pat_q   <= pat_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            vld_q   <= vld_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            done_q  <= done_d;
            out_q   <= out_d;
        end
    end
endmodule

// File: tb/tb_isp_frame_src.sv
// tb_isp_frame_src: directed and randomized frame checks against a cycle-position stream model
module tb_isp_frame_src;
    localparam int DW = 16;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int HW = 4;
    localparam int VW = 4;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [1:0]    src_sel = '0;
    logic [7:0]    hblank = '0;
    logic [DW-1:0] pat_val = '0;
    logic [DW-1:0] mem_rd_data;
    logic          mem_rd_en, pixel_data_out_vld, sof, eol, frame_done, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] pixel_data_out;
    logic [DW-1:0] mem [2**AW];
    int            tests = 0;
    int            fails = 0;

    isp_frame_src #(.DW(DW), .H(H), .V(V), .HW(HW), .VW(VW), .AW(AW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .src_sel(src_sel),
        .hblank(hblank), .pat_val(pat_val), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .pixel_data_out(pixel_data_out),
        .pixel_data_out_vld(pixel_data_out_vld), .sof(sof), .eol(eol),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, o, e);
        end
    endtask

    // Stream position q counts cycles from the first issue; a frame is V lines of H
    // pixels separated by hb idle cycles, with nothing after the final line.
    function automatic bit pix(input int q, input int hb, output int h, output int v);
        h = q % (H + hb);
        v = q / (H + hb);
        return q >= 0 && q < H * V + (V - 1) * hb && h < H;
    endfunction

    function automatic logic [DW-1:0] val(input logic [1:0] sel, input logic [DW-1:0] pat,
                                          input int h, input int v);
        if (sel == 2'd0) return mem[v * H + h];
        if (sel == 2'd1) return DW'(h + v);
        if (sel == 2'd2) return pat;
        return ((h ^ v) & 8) != 0 ? '1 : '0;
    endfunction

    // Runs one frame and checks every cycle up to the frame_done slot. cut_k ends the
    // frame early (abort or reset asserted in that cycle); disturb pokes start/config mid-frame.
    task automatic run_frame(input logic [1:0] sel, input logic [7:0] hb, input logic [DW-1:0] pat,
                             input int cut_k, input bit use_rst, input bit disturb);
        int len = H * V + (V - 1) * int'(hb);
        int h, v;
        bit rv, ov;
        @(negedge clk);
        src_sel = sel;
        hblank  = hb;
        pat_val = pat;
        abort   = 1'b0;
        start   = 1'b1;
        for (int k = 1; k <= len + 2; k++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            rv = pix(k - 1, int'(hb), h, v) && k <= cut_k;
            chk("rd_en", 32'(mem_rd_en), 32'(rv && sel == 2'd0));
            if (rv && sel == 2'd0) chk("addr", 32'(mem_addr), 32'(v * H + h));
            ov = pix(k - 3, int'(hb), h, v) && k <= cut_k;
            chk("vld", 32'(pixel_data_out_vld), 32'(ov));
            chk("sof", 32'(sof), 32'(ov && h == 0 && v == 0));
            chk("eol", 32'(eol), 32'(ov && h == H - 1));
            chk("frame_done", 32'(frame_done), 32'(ov && h == H - 1 && v == V - 1));
            if (ov) chk("data", 32'(pixel_data_out), 32'(val(sel, pat, h, v)));
            chk("busy", 32'(busy), 32'(k <= cut_k));
            if (disturb && k == 6) begin
                start   = 1'b1;
                src_sel = sel + 2'd1;
                hblank  = hb + 8'd2;
                pat_val = ~pat;
            end
            if (k == cut_k && use_rst) begin
                rstn = 1'b0;
                #1;
                chk("rst_zero", 32'({mem_rd_en, mem_addr, pixel_data_out, pixel_data_out_vld,
                                     sof, eol, frame_done, busy}), 32'(0));
            end else if (k == cut_k) begin
                abort = 1'b1;
            end
            if (use_rst && k == cut_k + 2) rstn = 1'b1;
        end
    endtask

    task automatic idle(input int n, input bit poke);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_vld", 32'(pixel_data_out_vld), 32'(0));
            chk("idle_busy", 32'(busy), 32'(0));
            chk("idle_rd", 32'(mem_rd_en), 32'(0));
            start = poke;
            abort = poke;
        end
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) mem[i] = DW'(i);
        repeat (3) @(negedge clk);
        chk("reset_outs", 32'({mem_rd_en, mem_addr, pixel_data_out, pixel_data_out_vld,
                               sof, eol, frame_done, busy}), 32'(0));
        rstn = 1'b1;
        idle(2, 1'b0);
        run_frame(2'd0, 8'd0, '0, 1000, 1'b0, 1'b0);
        idle(2, 1'b0);
        run_frame(2'd0, 8'd3, '0, 1000, 1'b0, 1'b0);
        run_frame(2'd1, 8'd0, '0, 1000, 1'b0, 1'b0);
        run_frame(2'd2, 8'd0, 16'h0ABC, 1000, 1'b0, 1'b0);
        run_frame(2'd3, 8'd1, '0, 1000, 1'b0, 1'b0);
        run_frame(2'd0, 8'd2, '0, 1000, 1'b0, 1'b1);
        idle(2, 1'b0);
        run_frame(2'd0, 8'd0, '0, 10, 1'b0, 1'b0);
        run_frame(2'd0, 8'd0, '0, 1000, 1'b0, 1'b0);
        idle(3, 1'b1);
        run_frame(2'd0, 8'd1, '0, 20, 1'b1, 1'b0);
        idle(1, 1'b0);
        run_frame(2'd0, 8'd1, '0, 1000, 1'b0, 1'b0);
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 2**AW; i++) mem[i] = DW'($urandom);
            run_frame(2'($urandom_range(0, 3)), 8'($urandom_range(0, 4)), DW'($urandom),
                      1000, 1'b0, 1'b0);
            idle(int'($urandom_range(0, 2)), 1'b0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
